// File: rtl/lock_code_checker_pkg.sv
// lock_pkg: shared types and defaults for the lock code checker.
//   lock_state_t   - controller state encoding
//   DEF_*          - default parameter values
//   timer_width()  - width of the shared OPEN/LOCKOUT down-counter
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        ARMED   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } lock_state_t;

    localparam int DEF_CODE_W         = 16;
    localparam int DEF_MAX_TRIES      = 3;
    localparam int DEF_OPEN_CYCLES    = 256;
    localparam int DEF_LOCKOUT_CYCLES = 1024;

    // One timer serves both hold periods, so it must fit the longer of the two.
    function automatic int timer_width(input int open_cycles, input int lockout_cycles);
        int longest;
        longest = (open_cycles > lockout_cycles) ? open_cycles : lockout_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/lock_code_checker_if.sv
// lock_code_checker_if: card reader / LFSR / actuator signal bundle.
//   serial_bit    - LFSR serial output, sampled every clk
//   capture       - request a new code capture
//   card_code     - code presented by the card reader
//   card_valid    - one-cycle strobe qualifying card_code
//   code_ready    - captured code valid and armed
//   unlock        - lock actuator drive
//   alarm         - lockout indicator
//   busy          - high while shifting, open or locked out
//   attempts_left - remaining wrong tries before lockout
// master: the side that drives stimulus (reader/LFSR); slave: the checker.
interface lock_code_checker_if #(
    parameter int CODE_W    = lock_pkg::DEF_CODE_W,
    parameter int MAX_TRIES = lock_pkg::DEF_MAX_TRIES
);
    localparam int ATT_W = $clog2(MAX_TRIES + 1);

    logic              serial_bit;
    logic              capture;
    logic [CODE_W-1:0] card_code;
    logic              card_valid;
    logic              code_ready;
    logic              unlock;
    logic              alarm;
    logic              busy;
    logic [ATT_W-1:0]  attempts_left;

    modport master (
        output serial_bit, capture, card_code, card_valid,
        input  code_ready, unlock, alarm, busy, attempts_left
    );

    modport slave (
        input  serial_bit, capture, card_code, card_valid,
        output code_ready, unlock, alarm, busy, attempts_left
    );

endinterface

// File: rtl/lock_code_checker_code_shift_reg.sv
// code_shift_reg: serial-in/parallel-out code register with bit counter.
//   clk        - system clock
//   reset      - synchronous active-high reset
//   shift_en   - shift one bit in this cycle
//   serial_bit - incoming bit; the first bit shifted ends in the MSB
//   code       - parallel code
//   done       - high in the cycle that samples the last bit
module code_shift_reg #(
    parameter int CODE_W = lock_pkg::DEF_CODE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              serial_bit,
    output logic [CODE_W-1:0] code,
    output logic              done
);

    localparam int CNT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CODE_W - 1);

    logic [CNT_W-1:0] bit_cnt;

    assign done = shift_en && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            code    <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            code <= {code[CODE_W-2:0], serial_bit};
            // Wrapping on the last bit leaves the counter at zero for the
            // next capture, so no separate clear is needed.
            if (done) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lock_code_checker.sv
// lock_code_checker: captures a one-time unlock code from the LFSR stream and
// checks card presentations against it, with limited retries and lockout.
//   clk   - system clock
//   reset - synchronous active-high reset
//   bus   - lock_code_checker_if.slave (see interface header for signals)
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for capture; cards ignored
// SHIFT   | deserialising CODE_W LFSR bits into the code register
// ARMED   | code valid; comparing card presentations
// OPEN    | unlock held for OPEN_CYCLES
// LOCKOUT | alarm held for LOCKOUT_CYCLES after the final wrong try
module lock_code_checker
    import lock_pkg::*;
#(
    parameter int CODE_W         = DEF_CODE_W,
    parameter int MAX_TRIES      = DEF_MAX_TRIES,
    parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input logic                   clk,
    input logic                   reset,
    lock_code_checker_if.slave    bus
);

    localparam int TMR_W = timer_width(OPEN_CYCLES, LOCKOUT_CYCLES);
    localparam int ATT_W = $clog2(MAX_TRIES + 1);

    // Loaded with N-1 so the hold lasts exactly N cycles including entry.
    localparam logic [TMR_W-1:0] OPEN_LOAD    = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [ATT_W-1:0] ATT_FULL     = ATT_W'(MAX_TRIES);
    localparam logic [ATT_W-1:0] ATT_ONE      = ATT_W'(1);

    lock_state_t       state, state_nx;
    logic [TMR_W-1:0]  timer, timer_nx;
    logic [ATT_W-1:0]  attempts, attempts_nx;
    logic [CODE_W-1:0] code;
    logic              shift_en;
    logic              shift_done;
    logic              code_match;

    logic              code_ready_q;
    logic              unlock_q;
    logic              alarm_q;
    logic              busy_q;

    code_shift_reg #(
        .CODE_W(CODE_W)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (shift_en),
        .serial_bit (bus.serial_bit),
        .code       (code),
        .done       (shift_done)
    );

    assign shift_en   = (state == SHIFT);
    assign code_match = (bus.card_code == code);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            attempts     <= ATT_FULL;
            code_ready_q <= 1'b0;
            unlock_q     <= 1'b0;
            alarm_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_nx;
            timer        <= timer_nx;
            attempts     <= attempts_nx;
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            code_ready_q <= (state_nx == ARMED);
            unlock_q     <= (state_nx == OPEN);
            alarm_q      <= (state_nx == LOCKOUT);
            busy_q       <= (state_nx == SHIFT) || (state_nx == OPEN) ||
                            (state_nx == LOCKOUT);
        end
    end

    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        attempts_nx = attempts;

        case (state)
            IDLE: begin
                if (bus.capture) begin
                    state_nx = SHIFT;
                end
            end

            SHIFT: begin
                if (shift_done) begin
                    state_nx = ARMED;
                end
            end

            ARMED: begin
                // A card presentation takes precedence over a re-capture.
                if (bus.card_valid) begin
                    if (code_match) begin
                        state_nx    = OPEN;
                        timer_nx    = OPEN_LOAD;
                        attempts_nx = ATT_FULL;
                    end else if (attempts > ATT_ONE) begin
                        attempts_nx = attempts - 1'b1;
                    end else begin
                        state_nx    = LOCKOUT;
                        timer_nx    = LOCKOUT_LOAD;
                        attempts_nx = '0;
                    end
                end else if (bus.capture) begin
                    state_nx    = SHIFT;
                    attempts_nx = ATT_FULL;
                end
            end

            OPEN: begin
                if (timer == '0) begin
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end

            LOCKOUT: begin
                if (timer == '0) begin
                    state_nx    = IDLE;
                    attempts_nx = ATT_FULL;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.code_ready    = code_ready_q;
    assign bus.unlock        = unlock_q;
    assign bus.alarm         = alarm_q;
    assign bus.busy          = busy_q;
    assign bus.attempts_left = attempts;

endmodule

// File: doc/lock_code_checker.md
Name: lock_code_checker

Overview:
- Downstream consumer of the LFSR serial output (q15).
- On a capture request, deserialises CODE_W consecutive LFSR bits into a one-time unlock code.
- Compares presented card codes against that code and drives the door-unlock pulse, limited retries and an alarm lockout.
- Sits between the LFSR stage and the lock actuator/indicator logic.

Parameters:
CODE_W, 16, width of captured code and of card_code
MAX_TRIES, 3, wrong card presentations allowed before lockout (>=1)
OPEN_CYCLES, 256, clock cycles unlock stays high after a match (>=1)
LOCKOUT_CYCLES, 1024, clock cycles alarm stays high after the final wrong try (>=1)

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
serial_bit  in  1  LFSR serial output (q15), sampled every clk
capture  in  1  active-high level/pulse; requests a new code capture
card_code  in  CODE_W  code presented by the card reader
card_valid  in  1  one-cycle strobe qualifying card_code
code_ready  out  1  captured code valid and armed
unlock  out  1  drives lock actuator
alarm  out  1  lockout indicator
busy  out  1  high in SHIFT, OPEN, LOCKOUT
attempts_left  out  $clog2(MAX_TRIES+1)  remaining tries

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset (priority over everything, including mid-shift, mid-open and mid-lockout):
  - state IDLE; code register 0; bit/timer counters 0.
  - code_ready, unlock, alarm, busy = 0; attempts_left = MAX_TRIES.
- All outputs are registered.
- States: IDLE, SHIFT, ARMED, OPEN, LOCKOUT.
- IDLE:
  - capture=1 -> SHIFT; bit_cnt=0.
  - card_valid ignored.
- SHIFT:
  - Every cycle: code <= {code[CODE_W-2:0], serial_bit}; bit_cnt++. The first sampled bit ends in the MSB.
  - The cycle sampling bit CODE_W-1 -> ARMED; code_ready=1 the following cycle.
  - Capture spans exactly CODE_W cycles; code_ready rises CODE_W cycles after the capture edge.
  - capture and card_valid ignored.
- ARMED:
  - card_valid && card_code==code -> OPEN; unlock=1 from the next cycle; code_ready cleared (code is single-use); attempts_left restored to MAX_TRIES.
  - card_valid && mismatch, attempts_left>1 -> stay ARMED; attempts_left decrements next cycle.
  - card_valid && mismatch, attempts_left==1 -> LOCKOUT; attempts_left=0, alarm=1, code_ready=0 next cycle.
  - capture=1 without card_valid -> SHIFT (re-capture); code_ready=0; attempts_left=MAX_TRIES.
  - capture and card_valid in the same cycle: card_valid wins, capture dropped.
- OPEN:
  - unlock held high for exactly OPEN_CYCLES cycles, then IDLE with unlock=0.
  - Inputs ignored.
- LOCKOUT:
  - alarm held high for exactly LOCKOUT_CYCLES cycles, then IDLE with alarm=0 and attempts_left=MAX_TRIES.
  - Inputs ignored.
- Timer: a single down-counter shared by OPEN and LOCKOUT, width $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)+1). No wrap; loaded on state entry.
- Comparison is a full CODE_W-bit equality; no partial match.
- unlock and alarm are never high together.

Decomposition:
- Package lock_pkg:
  - state enum lock_state_t {IDLE, SHIFT, ARMED, OPEN, LOCKOUT}.
  - default parameter constants.
  - function returning the timer width.
- Sub-module code_shift_reg (CODE_W):
  - ports: clk, reset, shift_en, serial_bit, code, done.
  - serial-in/parallel-out register plus bit counter.
- FSM, retry counter and timer stay in the top level.

Test Plan:
1. Reset, then capture pulse with serial_bit stream 1010_1100_0011_0101 (MSB first) -> code_ready rises 16 cycles after capture; internal code = 16'hAC35; busy high during the 16 cycles.
2. Armed with 16'hAC35; card_valid with 16'hAC35 -> unlock high next cycle for exactly 256 cycles; code_ready=0; returns to IDLE; attempts_left=3.
3. Armed; three card_valid with 16'h0000 -> attempts_left 2, 1, then alarm=1 for 1024 cycles; unlock never asserts; afterwards attempts_left=3, state IDLE.
4. Two wrong tries (attempts_left=1), then correct code -> unlock asserts; attempts_left restored to 3.
5. Reset asserted at shift bit 7, at OPEN cycle 100, and at LOCKOUT cycle 500 -> all outputs return to reset values the next cycle; a fresh capture works normally.
6. In ARMED, capture and correct card_valid in the same cycle -> unlock asserts, no re-capture. In OPEN, card_valid/capture -> ignored, unlock duration unchanged.
